register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
- Parametrised successor to the core's 15+PC register file.
- Adds configurable width and depth, a PC-mapped index, and two write ports: ALU writeback (A) and load writeback (B).
- Adds same-cycle write-to-read bypass and a per-register pending scoreboard for multicycle loads.
- Sits between decode (read ports, issue) and the writeback stages. Drives operand values and per-operand busy flags to the hazard unit.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.
- PC_IDX, 15, index mapped to pc_in. It is not stored and never written.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- we_a  in  1  ALU writeback enable.
- wa_a  in  ADDR_W  ALU writeback address.
- wd_a  in  WIDTH  ALU writeback data.
- we_b  in  1  load writeback enable; also clears pending.
- wa_b  in  ADDR_W  load writeback address.
- wd_b  in  WIDTH  load writeback data.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- pc_in  in  WIDTH  value returned when reading PC_IDX.
- issue_valid  in  1  a load is issued this cycle.
- issue_rd  in  ADDR_W  destination of the issued load.
- flush  in  1  synchronous clear of all pending bits.
- rd1  out  WIDTH  read data, port 1.
- rd2  out  WIDTH  read data, port 2.
- rd1_busy  out  1  operand 1 awaits an outstanding load.
- rd2_busy  out  1  operand 2 awaits an outstanding load.
- wr_collision  out  1  sticky flag: both write ports targeted the same address in one cycle.

Behaviour:
- Reset (async, rst=1):
  - All stored registers = 0; all pending bits = 0; wr_collision = 0.
  - While rst is held: rd1/rd2 = 0 for non-PC addresses, pc_in for PC_IDX; busy flags = 0.
  - Reset mid-load discards the pending state. A later we_b to that register is a plain write.
- Storage:
  - NUM_REGS-1 registers (every index except PC_IDX).
  - Writes commit on the rising edge.
  - Writes addressed to PC_IDX are ignored on both ports.
- Write priority:
  - we_a && we_b && wa_a==wa_b (not PC_IDX): port B's data is written.
  - wr_collision sets on that edge and holds until reset.
- Read (combinational, zero latency), evaluated in this order:
  1. raN==PC_IDX -> pc_in.
  2. we_b && wa_b==raN -> wd_b.
  3. we_a && wa_a==raN -> wd_a.
  4. Otherwise the stored value.
- Both ports are independent; ra1==ra2 is legal and both return the same value.
- Scoreboard, evaluated on each edge:
  - Precedence: flush > issue set > clear.
  - flush=1: all pending bits cleared. issue_valid on the same cycle is dropped.
  - issue_valid && issue_rd!=PC_IDX: pending[issue_rd] <= 1. This wins over a same-cycle we_b to the same register (the new load is outstanding).
  - we_b: pending[wa_b] <= 0, unless overridden by the set rule.
  - Re-issue to an already pending register keeps it at 1. No count is kept; a single outstanding load per register is guaranteed by the hazard unit.
  - we_a to a pending register writes data but does not clear pending.
- Busy (combinational):
  - rdN_busy = pending[raN] && !(we_b && wa_b==raN) && raN!=PC_IDX.
  - The bypassed load result is therefore usable in the same cycle.
  - Issue this cycle does not raise busy until the next cycle.
- No X may propagate from unwritten entries; all entries are defined from reset.

Test Plan:
- Reset, then read all 16 addresses with pc_in=0x0000_1000 -> 0 everywhere except ra=15 -> 0x1000; busy flags 0; wr_collision 0.
- we_a, wa_a=3, wd_a=0xDEAD_BEEF with ra1=3 in the same cycle -> rd1=0xDEADBEEF combinationally; next cycle with we_a=0, rd1=0xDEADBEEF from storage. we_a to wa_a=15 -> ra=15 still returns pc_in.
- we_a (wa_a=5, 0x11) and we_b (wa_b=5, 0x22) in one cycle -> ra1=5 reads 0x22 both that cycle and after; wr_collision=1 and stays 1 until rst.
- issue_valid with issue_rd=7; next cycle ra2=7 -> rd2_busy=1. we_b, wa_b=7, wd_b=0x55 -> same cycle rd2_busy=0, rd2=0x55; next cycle pending cleared.
- Same cycle: issue_valid with issue_rd=9, and we_b with wa_b=9 -> pending[9]=1 afterwards. Then flush together with issue_valid, issue_rd=4 -> pending[9]=0 and pending[4]=0.
- Set pending[2], assert rst asynchronously mid-cycle -> rd1_busy (ra1=2) drops immediately and rd1=0; after release, we_b to reg 2 writes normally.

Source files
------------

// File: rtl/register_file_sb.sv
// ============================================================================
// Module   : register_file_sb
// Brief    : Parametrised register file with PC-mapped index, ALU/load write
//            ports, same-cycle write-to-read bypass and load pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [WIDTH-1:0]  wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [WIDTH-1:0]  wd_b,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic              wr_collision
);

    localparam int              c_NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_ADDR = ADDR_W'(PC_IDX);

    logic [WIDTH-1:0]      r_regs_q    [c_NUM_REGS];
    logic [WIDTH-1:0]      w_regs_d    [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_pending_q;
    logic [c_NUM_REGS-1:0] w_pending_d;
    logic                  r_collision_q;
    logic                  w_collision_d;

    // Port B is applied last so it wins when both ports hit the same entry.
    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_regs_d[i] = r_regs_q[i];
        end
        if (we_a && (wa_a != c_PC_ADDR)) begin
            w_regs_d[wa_a] = wd_a;
        end
        if (we_b && (wa_b != c_PC_ADDR)) begin
            w_regs_d[wa_b] = wd_b;
        end
    end

    // Issue is applied after the load-return clear so a new load stays outstanding.
    always_comb begin
        w_pending_d = r_pending_q;
        if (flush) begin
            w_pending_d = '0;
        end else begin
            if (we_b) begin
                w_pending_d[wa_b] = 1'b0;
            end
            if (issue_valid && (issue_rd != c_PC_ADDR)) begin
                w_pending_d[issue_rd] = 1'b1;
            end
        end
    end

    always_comb begin
        w_collision_d = r_collision_q;
        if (we_a && we_b && (wa_a == wa_b) && (wa_a != c_PC_ADDR)) begin
            w_collision_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs_q[i] <= '0;
            end
            r_pending_q   <= '0;
            r_collision_q <= 1'b0;
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs_q[i] <= w_regs_d[i];
            end
            r_pending_q   <= w_pending_d;
            r_collision_q <= w_collision_d;
        end
    end

    // Bypass is suppressed while reset is held so reads show the cleared state.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [WIDTH-1:0]  stored,
        input logic              in_rst,
        input logic              wea,
        input logic [ADDR_W-1:0] waa,
        input logic [WIDTH-1:0]  wda,
        input logic              web,
        input logic [ADDR_W-1:0] wab,
        input logic [WIDTH-1:0]  wdb,
        input logic [WIDTH-1:0]  pc
    );
        logic [WIDTH-1:0] val;
        val = in_rst ? '0 : stored;
        if (!in_rst && wea && (waa == ra)) val = wda;
        if (!in_rst && web && (wab == ra)) val = wdb;
        if (ra == c_PC_ADDR)               val = pc;
        return val;
    endfunction

    always_comb begin
        rd1 = read_mux(ra1, r_regs_q[ra1], rst, we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in);
        rd2 = read_mux(ra2, r_regs_q[ra2], rst, we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in);
    end

    always_comb begin
        rd1_busy = r_pending_q[ra1] && !(we_b && (wa_b == ra1)) && (ra1 != c_PC_ADDR);
        rd2_busy = r_pending_q[ra2] && !(we_b && (wa_b == ra2)) && (ra2 != c_PC_ADDR);
    end

    assign wr_collision = r_collision_q;

endmodule

`default_nettype wire
